fpu_issue_ctrl: RTL and testbench
=================================

FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 63: the maximum number of WAIT cycles before an abort (used only when FPU_ISSUE_TIMEOUT_EN is defined).
REQ-002 SHALL have port in_Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port in_Rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have the pipeline-side ports:
- in_valid, input, 1: an FP instruction is presented.
- in_FPU_Op, input, 4: operation code.
- in_rd, input, 5: destination register.
- in_rs1_data, input, 32: operand A.
- in_rs2_data, input, 32: operand B.
- out_ready, output, 1: controller accepts an instruction this cycle.
REQ-005 SHALL have the FPU-side ports:
- out_rs1, output, 32 and out_rs2, output, 32: operands.
- out_FPU_Op, output, 4: operation code.
- out_start, output, 1: divide launch pulse.
- in_fpu_stall, input, 1: divider busy.
- in_fpu_data, input, 64: FPU result.
REQ-006 SHALL have the writeback ports:
- out_wb_valid, output, 1: result valid.
- out_wb_rd, output, 5: destination register.
- out_wb_data, output, 64: result data.
- out_wb_is_int, output, 1: result targets the integer register file.
- out_illegal, output, 1: unsupported opcode.
- out_timeout, output, 1: divide aborted.

Function
REQ-007 SHALL implement the FSM states IDLE, EXEC, LAUNCH, WAIT and WB.
REQ-008 SHALL drive out_ready = 1 only in IDLE; a transfer occurs when in_valid && out_ready.
REQ-009 SHALL, on a transfer, latch op, rd, rs1 and rs2 into holding registers and drive out_rs1, out_rs2 and out_FPU_Op from those registers until the next transfer.
REQ-010 SHALL go IDLE->LAUNCH when the latched op == 4'b0010 (divide), and IDLE->EXEC for every other op.
REQ-011 SHALL, in EXEC, capture in_fpu_data into out_wb_data at the clock edge and go to WB; latency from transfer edge to out_wb_valid is 2 cycles.
REQ-012 SHALL assert out_start only in LAUNCH (exactly one cycle), then go to WAIT.
REQ-013 SHALL treat in_fpu_stall as follows: the FPU asserts it in the cycle after out_start and deasserts it when the quotient is valid.
REQ-014 SHALL ignore in_fpu_stall during the first WAIT cycle; from the second WAIT cycle on, in_fpu_stall == 0 captures in_fpu_data and goes to WB.
REQ-015 SHALL assert out_wb_valid only in WB (exactly one cycle), with out_wb_rd equal to the latched rd; WB->IDLE unconditionally.
REQ-016 SHALL set out_wb_is_int = 1 for op 4'b0100 (compare) and op 4'b0110 (convert), and 0 otherwise; it is valid with out_wb_valid.
REQ-017 SHALL complete ops 4'b1000-4'b1111 via EXEC with out_wb_data = 64'd0, out_wb_is_int = 0, and out_illegal = 1 in the WB cycle.
REQ-018 SHALL ignore in_valid outside IDLE: no latch, operands unchanged; upstream holds its request.
REQ-019 SHALL hold out_wb_data, out_wb_rd and out_wb_is_int stable after WB until the next capture.

Reset
REQ-020 SHALL, with in_Rst high at a clock edge, go to IDLE; all registered outputs (out_start, out_wb_valid, out_wb_data, out_wb_rd, out_wb_is_int, out_illegal, out_timeout, holding registers) become 0; out_ready = 1 from the following cycle.
REQ-021 SHALL treat reset in any non-IDLE state (including WAIT) as a discard: no writeback for the in-flight op and no wait for in_fpu_stall to fall.
REQ-022 SHALL give reset priority over a simultaneous in_valid transfer.

Configuration
REQ-023 SHALL, when FPU_ISSUE_TIMEOUT_EN is defined, count WAIT cycles; when the count reaches TIMEOUT_CYC with in_fpu_stall still 1, go to WB with out_wb_data = 64'd0 and out_timeout = 1 for that WB cycle; the counter clears on entry to WAIT.
REQ-024 SHALL, when FPU_ISSUE_TIMEOUT_EN is undefined, have no counter; WAIT persists indefinitely and out_timeout is tied 0 (port present).

Verification
REQ-025 SHALL cover add: op 0000, rs1 = 0x3F800000, rs2 = 0x40000000 -> out_wb_valid 2 cycles after transfer, out_wb_data = 0x0000000040400000, out_wb_is_int = 0.
REQ-026 SHALL cover divide: op 0010, stall model high 10 cycles -> out_start a 1-cycle pulse; out_wb_valid in the cycle after stall falls; out_ready low throughout.
REQ-027 SHALL cover compare: op 0100, equal operands -> out_wb_is_int = 1, out_wb_rd = the latched rd, in_valid held during busy cycles accepted only after WB.
REQ-028 SHALL cover illegal op: op 1010 -> out_illegal = 1 and out_wb_data = 0 in the WB cycle.
REQ-029 SHALL cover reset in WAIT: in_Rst pulsed on the 3rd WAIT cycle -> no out_wb_valid, out_ready = 1 next cycle, all outputs 0.
REQ-030 SHALL cover timeout: FPU_ISSUE_TIMEOUT_EN defined, TIMEOUT_CYC = 4, stall held high -> WB after 4 WAIT cycles with out_timeout = 1 and out_wb_data = 0.

Source files
------------

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: FP instruction issue/writeback controller; FPU_ISSUE_TIMEOUT_EN adds a divide abort timer.
module fpu_issue_ctrl #(
  parameter int TIMEOUT_CYC = 63
) (
  input  logic        in_Clk,
  input  logic        in_Rst,
  input  logic        in_valid,
  input  logic [3:0]  in_FPU_Op,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  output logic        out_ready,
  output logic [31:0] out_rs1,
  output logic [31:0] out_rs2,
  output logic [3:0]  out_FPU_Op,
  output logic        out_start,
  input  logic        in_fpu_stall,
  input  logic [63:0] in_fpu_data,
  output logic        out_wb_valid,
  output logic [4:0]  out_wb_rd,
  output logic [63:0] out_wb_data,
  output logic        out_wb_is_int,
  output logic        out_illegal,
  output logic        out_timeout
);
  typedef enum logic [2:0] {IDLE, EXEC, LAUNCH, WAIT, WB} state_t;
  state_t state, next;
  logic [4:0] rd_q;
  logic first_q, illegal_q, xfer, wait_done, expire, capture;
  assign out_ready = state == IDLE;
  assign out_start = state == LAUNCH;
  assign out_wb_valid = state == WB;
  assign out_illegal = out_wb_valid && illegal_q;
  assign xfer = in_valid && out_ready;
  // the divider raises stall one cycle late, so the first WAIT cycle is blind
  assign wait_done = state == WAIT && !first_q && !in_fpu_stall;
  assign capture = state == EXEC || wait_done || expire;
`ifdef FPU_ISSUE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt;
  logic timeout_q;
  assign expire = state == WAIT && in_fpu_stall && cnt == CW'(TIMEOUT_CYC - 1);
  assign out_timeout = out_wb_valid && timeout_q;
  always_ff @(posedge in_Clk) begin
    if (in_Rst) begin
      cnt <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt <= state == WAIT ? cnt + CW'(1) : '0;
      if (capture) timeout_q <= expire;
    end
  end
`else
  assign expire = 1'b0;
  assign out_timeout = 1'b0;
`endif
  always_ff @(posedge in_Clk) begin
    if (in_Rst) state <= IDLE;
    else state <= next;
  end
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = in_valid ? (in_FPU_Op == 4'b0010 ? LAUNCH : EXEC) : IDLE;
      EXEC:    next = WB;
      LAUNCH:  next = WAIT;
      WAIT:    next = wait_done || expire ? WB : WAIT;
      WB:      next = IDLE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge in_Clk) begin
    if (in_Rst) begin
      out_FPU_Op <= '0;
      rd_q <= '0;
      out_rs1 <= '0;
      out_rs2 <= '0;
      first_q <= 1'b0;
      illegal_q <= 1'b0;
      out_wb_data <= '0;
      out_wb_rd <= '0;
      out_wb_is_int <= 1'b0;
    end else begin
      if (xfer) begin
        out_FPU_Op <= in_FPU_Op;
        rd_q <= in_rd;
        out_rs1 <= in_rs1_data;
        out_rs2 <= in_rs2_data;
      end
      first_q <= state == LAUNCH;
      if (capture) begin
        out_wb_data <= (state == EXEC && out_FPU_Op[3]) || expire ? '0 : in_fpu_data;
        out_wb_rd <= rd_q;
        out_wb_is_int <= out_FPU_Op == 4'b0100 || out_FPU_Op == 4'b0110;
        illegal_q <= state == EXEC && out_FPU_Op[3];
      end
    end
  end
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: vector table plus divide/reset/timeout sequences, writeback checked by a scoreboard.
module tb_fpu_issue_ctrl;
  logic in_Clk = 1'b0, in_Rst = 1'b1, in_valid = 1'b0, in_fpu_stall = 1'b0;
  logic [3:0] in_FPU_Op = '0;
  logic [4:0] in_rd = '0;
  logic [31:0] in_rs1_data = '0, in_rs2_data = '0;
  logic [63:0] in_fpu_data = '0;
  logic out_ready, out_start, out_wb_valid, out_wb_is_int, out_illegal, out_timeout;
  logic [31:0] out_rs1, out_rs2;
  logic [3:0] out_FPU_Op;
  logic [4:0] out_wb_rd;
  logic [63:0] out_wb_data;
  int checks = 0, errors = 0;

  typedef struct {
    logic [3:0] op; logic [4:0] rd; logic [31:0] a, b; logic [63:0] fpu, data; logic is_int, ill;
  } vec_t;
  typedef struct {
    logic [63:0] data; logic [4:0] rd; logic is_int, ill, tmo;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  vec_t v[8];

  fpu_issue_ctrl #(.TIMEOUT_CYC(4)) dut (
    .in_Clk(in_Clk), .in_Rst(in_Rst), .in_valid(in_valid), .in_FPU_Op(in_FPU_Op), .in_rd(in_rd),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .out_ready(out_ready),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_FPU_Op(out_FPU_Op), .out_start(out_start),
    .in_fpu_stall(in_fpu_stall), .in_fpu_data(in_fpu_data), .out_wb_valid(out_wb_valid),
    .out_wb_rd(out_wb_rd), .out_wb_data(out_wb_data), .out_wb_is_int(out_wb_is_int),
    .out_illegal(out_illegal), .out_timeout(out_timeout)
  );

  always #5 in_Clk = ~in_Clk;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge in_Clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20 && !out_ready; i++) step();
    chk("ready_wait", out_ready, 1'b1);
  endtask

  task automatic drive(input logic [3:0] op, input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    in_FPU_Op = op;
    in_rd = rd;
    in_rs1_data = a;
    in_rs2_data = b;
  endtask

  task automatic div_seq(input logic [4:0] rd, input logic [63:0] q, input int hi, input bit late);
    wait_ready();
    drive(4'b0010, rd, 32'h41200000, 32'h40000000);
    in_fpu_data = 64'hBAD0BAD0BAD0BAD0;
    sb.push_back('{q, rd, 1'b0, 1'b0, 1'b0});
    step();
    chk("div_start", out_start, 1'b1);
    chk("div_ready", out_ready, 1'b0);
    in_valid = 1'b0;
    step();
    chk("div_start_pulse", out_start, 1'b0);
    if (late) begin
      step();
      chk("div_first_ignored", out_wb_valid, 1'b0);
    end
    in_fpu_stall = 1'b1;
    for (int i = 0; i < hi; i++) begin
      step();
      chk("div_busy", {out_wb_valid, out_ready, out_start}, 3'b000);
    end
    in_fpu_stall = 1'b0;
    in_fpu_data = q;
    step();
    chk("div_wb", out_wb_valid, 1'b1);
    step();
  endtask

  always @(negedge in_Clk) begin
    if (out_wb_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected rd=%0d data=%h expected no writeback", out_wb_rd, out_wb_data);
      end else begin
        e = sb.pop_front();
        chk("wb_data", out_wb_data, e.data);
        chk("wb_rd", out_wb_rd, e.rd);
        chk("wb_is_int", out_wb_is_int, e.is_int);
        chk("wb_illegal", out_illegal, e.ill);
        chk("wb_timeout", out_timeout, e.tmo);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    v[0] = '{4'b0000, 5'd5,  32'h3F800000, 32'h40000000, 64'h40400000, 64'h40400000, 1'b0, 1'b0};
    v[1] = '{4'b0100, 5'd6,  32'h40490FDB, 32'h40490FDB, 64'h1,        64'h1,        1'b1, 1'b0};
    v[2] = '{4'b0110, 5'd7,  32'h42280000, 32'h0,        64'h2A,       64'h2A,       1'b1, 1'b0};
    v[3] = '{4'b0011, 5'd8,  32'h40000000, 32'h40400000, 64'h40C00000, 64'h40C00000, 1'b0, 1'b0};
    v[4] = '{4'b1010, 5'd9,  32'h11111111, 32'h22222222, 64'hDEADBEEF, 64'h0,        1'b0, 1'b1};
    v[5] = '{4'b1111, 5'd31, 32'h33333333, 32'h44444444, 64'hFFFFFFFF, 64'h0,        1'b0, 1'b1};
    v[6] = '{4'b0111, 5'd1,  32'h55555555, 32'h66666666, 64'h12345678, 64'h12345678, 1'b0, 1'b0};
    v[7] = '{4'b0101, 5'd2,  32'h77777777, 32'h88888888, 64'hCAFEF00D, 64'hCAFEF00D, 1'b0, 1'b0};
    step();
    step();
    chk("rst_ready", out_ready, 1'b1);
    chk("rst_outs", {out_start, out_wb_valid, out_wb_is_int, out_illegal, out_timeout}, 5'b0);
    chk("rst_data", out_wb_data, 64'h0);
    chk("rst_hold", {out_rs1, out_rs2, out_FPU_Op, out_wb_rd}, 73'h0);
    in_Rst = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      wait_ready();
      drive(v[i].op, v[i].rd, v[i].a, v[i].b);
      in_fpu_data = v[i].fpu;
      sb.push_back('{v[i].data, v[i].rd, v[i].is_int, v[i].ill, 1'b0});
      step();
      in_valid = 1'b0;
      chk("vec_busy", {out_ready, out_wb_valid}, 2'b00);
      chk("vec_operands", {out_rs1, out_rs2, out_FPU_Op}, {v[i].a, v[i].b, v[i].op});
      step();
      chk("vec_latency", out_wb_valid, 1'b1);
      step();
      chk("vec_hold", {out_wb_data, out_wb_rd, out_wb_is_int}, {v[i].data, v[i].rd, v[i].is_int});
    end
    drive(4'b0100, 5'd3, 32'h40490FDB, 32'h40490FDB);
    in_fpu_data = 64'h1;
    sb.push_back('{64'h1, 5'd3, 1'b1, 1'b0, 1'b0});
    step();
    drive(4'b0000, 5'd4, 32'h3F800000, 32'h40000000);
    chk("held_exec", {out_ready, out_rs1, out_FPU_Op}, {1'b0, 32'h40490FDB, 4'b0100});
    step();
    in_fpu_data = 64'h40400000;
    chk("held_wb", {out_ready, out_rs1, out_FPU_Op}, {1'b0, 32'h40490FDB, 4'b0100});
    step();
    chk("held_idle", {out_ready, out_rs1}, {1'b1, 32'h40490FDB});
    sb.push_back('{64'h40400000, 5'd4, 1'b0, 1'b0, 1'b0});
    step();
    in_valid = 1'b0;
    chk("held_accept", {out_ready, out_rs1, out_FPU_Op}, {1'b0, 32'h3F800000, 4'b0000});
    step();
    step();
    div_seq(5'd10, 64'h40A00000, 10, 1'b0);
    div_seq(5'd11, 64'h3FC00000, 2, 1'b1);
    wait_ready();
    drive(4'b0010, 5'd12, 32'h41200000, 32'h40000000);
    step();
    in_valid = 1'b0;
    step();
    in_fpu_stall = 1'b1;
    step();
    step();
    in_Rst = 1'b1;
    step();
    in_Rst = 1'b0;
    in_fpu_stall = 1'b0;
    chk("rwait_ready", out_ready, 1'b1);
    chk("rwait_outs", {out_start, out_wb_valid, out_wb_is_int, out_illegal, out_timeout}, 5'b0);
    chk("rwait_data", {out_wb_data, out_wb_rd}, 69'h0);
    chk("rwait_hold", {out_rs1, out_rs2, out_FPU_Op}, 68'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rwait_no_wb", {out_wb_valid, out_ready}, 2'b01);
    end
    drive(4'b0000, 5'd13, 32'h12345678, 32'h9ABCDEF0);
    in_Rst = 1'b1;
    step();
    in_Rst = 1'b0;
    in_valid = 1'b0;
    chk("rst_prio", {out_ready, out_rs1}, {1'b1, 32'h0});
    step();
    chk("rst_prio_idle", {out_ready, out_wb_valid}, 2'b10);
    drive(4'b0010, 5'd14, 32'h41200000, 32'h0);
`ifdef FPU_ISSUE_TIMEOUT_EN
    sb.push_back('{64'h0, 5'd14, 1'b0, 1'b0, 1'b1});
    in_fpu_data = 64'h0123456789ABCDEF;
    step();
    in_valid = 1'b0;
    step();
    in_fpu_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("tmo_wait", out_wb_valid, 1'b0);
    end
    step();
    chk("tmo_wb", {out_wb_valid, out_timeout}, 2'b11);
    in_fpu_stall = 1'b0;
    step();
    chk("tmo_clear", out_timeout, 1'b0);
`else
    step();
    in_valid = 1'b0;
    step();
    in_fpu_stall = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      chk("notmo_wait", {out_wb_valid, out_timeout}, 2'b00);
    end
    in_fpu_stall = 1'b0;
    in_fpu_data = 64'h40200000;
    sb.push_back('{64'h40200000, 5'd14, 1'b0, 1'b0, 1'b0});
    step();
    chk("notmo_wb", {out_wb_valid, out_timeout}, 2'b10);
    step();
`endif
    step();
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
